// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, requester indices and arbiter FSM encodings for the
// register-file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_32    = 32;
  localparam int unsigned REG_ADDR_WIDTH_5 = 5;
  localparam int unsigned STARVE_LIMIT_4   = 4;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned REQ_DBG = 0;
  localparam int unsigned REQ_LD  = 1;
  localparam int unsigned REQ_ALU = 2;

  typedef enum logic [1:0] {
    ARB_NORMAL = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_arb_priority_select.sv
// Combinational one-hot grant: dbg > ld > alu, ALU promoted above ld when
// starving, and only dbg eligible once a lock is requested or held.
module regfile_write_arbiter_arb_priority_select
  import regfile_write_arbiter_pkg::*;
(
  input  logic               dbg_valid,
  input  logic               ld_valid,
  input  logic               alu_valid,
  input  logic               force_alu,
  input  arb_state_e         state,
  input  logic               lock_req,
  output logic [NUM_REQ-1:0] grant_c
);

  always_comb begin
    grant_c = '0;
    case (state)
      ARB_NORMAL: begin
        if (lock_req) begin
          grant_c[REQ_DBG] = dbg_valid;
        end else if (dbg_valid) begin
          grant_c[REQ_DBG] = 1'b1;
        end else if (force_alu) begin
          grant_c[REQ_ALU] = 1'b1;
        end else if (ld_valid) begin
          grant_c[REQ_LD] = 1'b1;
        end else if (alu_valid) begin
          grant_c[REQ_ALU] = 1'b1;
        end
      end
      ARB_LOCKED: grant_c[REQ_DBG] = dbg_valid;
      default:    grant_c = '0;
    endcase
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: debug/load/ALU requesters, ALU
// anti-starvation, debug lock FSM and a one-cycle registered write stage.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_32,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_5,
  parameter int unsigned STARVE_LIMIT   = STARVE_LIMIT_4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dbgValid,
  output logic                      dbgReady,
  input  logic [REG_ADDR_WIDTH-1:0] dbgAddr,
  input  logic [DATA_WIDTH-1:0]     dbgData,
  input  logic                      dbgLock,
  output logic                      dbgLocked,
  input  logic                      ldValid,
  output logic                      ldReady,
  input  logic [REG_ADDR_WIDTH-1:0] ldAddr,
  input  logic [DATA_WIDTH-1:0]     ldData,
  input  logic                      aluValid,
  output logic                      aluReady,
  input  logic [REG_ADDR_WIDTH-1:0] aluAddr,
  input  logic [DATA_WIDTH-1:0]     aluData,
  output logic                      writeEnable,
  output logic [REG_ADDR_WIDTH-1:0] desRegister,
  output logic [DATA_WIDTH-1:0]     writeData,
  output logic                      inflightValid
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e                state_q, state_d;
  logic [CNT_W-1:0]          starve_cnt;
  logic                      force_alu;
  logic [NUM_REQ-1:0]        grant;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;

  assign force_alu = aluValid && (starve_cnt == CNT_W'(STARVE_LIMIT));

  regfile_write_arbiter_arb_priority_select u_select (
    .dbg_valid (dbgValid),
    .ld_valid  (ldValid),
    .alu_valid (aluValid),
    .force_alu (force_alu),
    .state     (state_q),
    .lock_req  (dbgLock),
    .grant_c   (grant)
  );

  // Ready is the grant itself, forced low while reset is held.
  assign dbgReady = grant[REQ_DBG] & ~reset;
  assign ldReady  = grant[REQ_LD]  & ~reset;
  assign aluReady = grant[REQ_ALU] & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_NORMAL: if (dbgLock) state_d = ARB_DRAIN;
      ARB_DRAIN:  state_d = ARB_LOCKED;
      ARB_LOCKED: if (!dbgLock) state_d = ARB_NORMAL;
      default:    state_d = ARB_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbgLocked <= 1'b0;
    end else begin
      dbgLocked <= (state_d == ARB_LOCKED);
    end
  end

  // Counts consecutive cycles ALU waited; frozen while debug owns the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state_q != ARB_LOCKED) begin
      if (aluValid && !grant[REQ_ALU]) begin
        if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    if (grant[REQ_DBG]) begin
      sel_addr = dbgAddr;
      sel_data = dbgData;
    end else if (grant[REQ_LD]) begin
      sel_addr = ldAddr;
      sel_data = ldData;
    end else if (grant[REQ_ALU]) begin
      sel_addr = aluAddr;
      sel_data = aluData;
    end
  end

  // Writes to x0 are consumed but never enable the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      writeEnable   <= 1'b0;
      inflightValid <= 1'b0;
      desRegister   <= '0;
      writeData     <= '0;
    end else begin
      writeEnable   <= 1'b0;
      inflightValid <= 1'b0;
      if (|grant) begin
        desRegister   <= sel_addr;
        writeData     <= sel_data;
        writeEnable   <= (sel_addr != '0);
        inflightValid <= (sel_addr != '0);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter with a behavioural
// arbitration model feeding a write scoreboard drained by a monitor.
module tb_regfile_write_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          dbgValid, dbgReady, dbgLock, dbgLocked;
  logic [AW-1:0] dbgAddr;
  logic [DW-1:0] dbgData;
  logic          ldValid, ldReady;
  logic [AW-1:0] ldAddr;
  logic [DW-1:0] ldData;
  logic          aluValid, aluReady;
  logic [AW-1:0] aluAddr;
  logic [DW-1:0] aluData;
  logic          writeEnable, inflightValid;
  logic [AW-1:0] desRegister;
  logic [DW-1:0] writeData;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .dbgValid(dbgValid), .dbgReady(dbgReady), .dbgAddr(dbgAddr), .dbgData(dbgData),
    .dbgLock(dbgLock), .dbgLocked(dbgLocked),
    .ldValid(ldValid), .ldReady(ldReady), .ldAddr(ldAddr), .ldData(ldData),
    .aluValid(aluValid), .aluReady(aluReady), .aluAddr(aluAddr), .aluData(aluData),
    .writeEnable(writeEnable), .desRegister(desRegister), .writeData(writeData),
    .inflightValid(inflightValid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  // Requester-side pending requests: index 0 dbg, 1 ld, 2 alu.
  logic          rv[3];
  logic [AW-1:0] ra[3];
  logic [DW-1:0] rd[3];
  logic          lk, rst;
  logic [2:0]    obs;

  // Reference model: lock phase flags and ALU wait count.
  bit m_drain, m_locked;
  int starve;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic apply();
    dbgValid = rv[0]; dbgAddr = ra[0]; dbgData = rd[0];
    ldValid  = rv[1]; ldAddr  = ra[1]; ldData  = rd[1];
    aluValid = rv[2]; aluAddr = ra[2]; aluData = rd[2];
    reset = rst; dbgLock = lk;
  endtask

  // One cycle: drive, predict the winner, check readys, queue the write.
  task automatic step();
    int g;
    apply();
    #1;
    g = 3;
    if (!rst && !m_drain) begin
      if (m_locked || lk) begin
        if (rv[0]) g = 0;
      end else if (rv[0]) g = 0;
      else if (rv[2] && starve >= LIM) g = 2;
      else if (rv[1]) g = 1;
      else if (rv[2]) g = 2;
    end
    obs = {aluReady, ldReady, dbgReady};
    chk("dbgReady", 32'(dbgReady), 32'(g == 0));
    chk("ldReady",  32'(ldReady),  32'(g == 1));
    chk("aluReady", 32'(aluReady), 32'(g == 2));
    chk("dbgLocked", 32'(dbgLocked), 32'(m_locked));
    if (g != 3 && ra[g] != '0) q.push_back('{cyc + 1, ra[g], rd[g]});
    if (rst) begin
      m_drain = 0; m_locked = 0; starve = 0;
    end else begin
      if (!m_locked) starve = (rv[2] && g != 2) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
      if (m_drain) begin
        m_drain = 0; m_locked = 1;
      end else if (m_locked) m_locked = lk;
      else m_drain = lk;
    end
    if (g != 3) rv[g] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
  endtask

  // Monitor: every cycle the output stage must match the queue head.
  initial begin
    exp_t e;
    logic exp_we;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        while (q.size() > 0 && q[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_write cyc=%0d actual=none required=x%0d", cyc, q[0].addr);
          void'(q.pop_front());
        end
        exp_we = (q.size() > 0) && (q[0].due == cyc);
        chk("writeEnable", 32'(writeEnable), 32'(exp_we));
        chk("inflightValid", 32'(inflightValid), 32'(exp_we));
        if (exp_we) begin
          e = q.pop_front();
          chk("desRegister", 32'(desRegister), 32'(e.addr));
          chk("writeData", writeData, e.data);
        end
      end
    end
  end

  initial begin
    m_drain = 0; m_locked = 0; starve = 0;
    // Reset held two cycles with every requester valid.
    rst = 1'b1; lk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b1; ra[i] = AW'(i + 1); rd[i] = $urandom;
    end
    apply();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    clear_reqs();
    chk("reset_desRegister", 32'(desRegister), 32'd0);
    chk("reset_writeData", writeData, 32'd0);

    // Single load write.
    rv[1] = 1'b1; ra[1] = 5'd5; rd[1] = 32'hA5A5A5A5;
    step();
    chk("t1_ldReady", 32'(obs), 32'b010);
    step();
    step();

    // Three-way contention drains in priority order.
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b1; ra[i] = AW'(i + 1); rd[i] = $urandom;
    end
    for (int i = 0; i < 5; i++) step();

    // Continuous load traffic starves ALU until the fifth cycle.
    rv[2] = 1'b1; ra[2] = 5'd9; rd[2] = $urandom;
    for (int i = 0; i < 7; i++) begin
      if (!rv[1]) begin
        rv[1] = 1'b1; ra[1] = AW'($urandom_range(1, 31)); rd[1] = $urandom;
      end
      step();
      chk("t3_grant", 32'(obs), (i == 4) ? 32'b100 : 32'b010);
    end
    for (int i = 0; i < 3; i++) step();

    // ALU write to x0 is consumed silently.
    rv[2] = 1'b1; ra[2] = 5'd0; rd[2] = 32'hFFFFFFFF;
    step();
    chk("t4_aluReady", 32'(obs), 32'b100);
    step();
    step();

    // Debug lock: drain, locked, debug write, release.
    rv[1] = 1'b1; ra[1] = 5'd4; rd[1] = $urandom;
    lk = 1'b1;
    step();
    chk("t5_lock_blocks_ld", 32'(obs), 32'b000);
    step();
    step();
    chk("t5_locked", 32'(dbgLocked), 32'd1);
    rv[0] = 1'b1; ra[0] = 5'd7; rd[0] = 32'h12345678;
    step();
    chk("t5_dbg_grant", 32'(obs), 32'b001);
    step();
    lk = 1'b0;
    step();
    step();
    chk("t5_ld_resumes", 32'(obs), 32'b010);
    step();

    // Reset right after an ALU grant, then reset out of LOCKED.
    rv[2] = 1'b1; ra[2] = 5'd11; rd[2] = $urandom;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    lk = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0; lk = 1'b0;
    rv[1] = 1'b1; ra[1] = 5'd13; rd[1] = $urandom;
    step();
    chk("t6_normal_after_reset", 32'(obs), 32'b010);
    step();

    // Randomized traffic with lock toggles and occasional resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!rv[i] && ($urandom % 3 != 0)) begin
          rv[i] = 1'b1;
          ra[i] = ($urandom % 4 == 0) ? AW'(0) : AW'($urandom);
          rd[i] = $urandom;
        end
      end
      if ($urandom % 25 == 0) lk = ~lk;
      rst = ($urandom % 80 == 0);
      step();
    end

    rst = 1'b0; lk = 1'b0;
    for (int i = 0; i < 8; i++) step();
    clear_reqs();
    for (int i = 0; i < 3; i++) step();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
